hmmm_control_seq: RTL and testbench

HMMM_CONTROL_SEQ -- requirements
Module: hmmm_control_seq

---
 rtl/hmmm_pkg.sv | 27 ++
 rtl/hmmm_decode.sv | 33 +++
 rtl/hmmm_control_seq.sv | 163 ++++++++++++++++
 tb/tb_hmmm_control_seq.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/hmmm_pkg.sv
// hmmm_pkg: shared state, instruction-class and encoding definitions for the HMMM control sequencer
package hmmm_pkg;
  typedef enum logic [2:0] {FETCH_A, FETCH_B, DECODE, EX1, EX2, EX3, HALTED} state_e;
  typedef enum logic [3:0] {CL_HALT, CL_READ, CL_WRITE, CL_SETN, CL_LOADN, CL_STOREN, CL_ALU, CL_JUMPN, CL_ILL} class_e;
  localparam logic [3:0] OP_HALT   = 4'h0;
  localparam logic [3:0] OP_IO     = 4'h1;
  localparam logic [3:0] OP_SETN   = 4'h2;
  localparam logic [3:0] OP_LOADN  = 4'h3;
  localparam logic [3:0] OP_STOREN = 4'h4;
  localparam logic [3:0] OP_ADD    = 4'h6;
  localparam logic [3:0] OP_SUB    = 4'h7;
  localparam logic [3:0] OP_MUL    = 4'h8;
  localparam logic [3:0] OP_DIV    = 4'h9;
  localparam logic [3:0] OP_MOD    = 4'hA;
  localparam logic [3:0] OP_JUMPN  = 4'hB;
  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_MUL = 3'd2;
  localparam logic [2:0] ALU_DIV = 3'd3;
  localparam logic [2:0] ALU_MOD = 3'd4;
  localparam logic [7:0] IO_READ  = 8'h01;
  localparam logic [7:0] IO_WRITE = 8'h02;
  // ALU opcodes are contiguous, so the ALU encoding is the offset from ADD
  function automatic logic [2:0] alu_enc(logic [3:0] op);
    return 3'(op - OP_ADD);
  endfunction
endpackage

// File: rtl/hmmm_decode.sv
// hmmm_decode: classifies an HMMM instruction word and flags illegal encodings
module hmmm_decode import hmmm_pkg::*; #(
  parameter int NREG = 16
) (
  input  logic [15:0] ir_i,
  output logic [3:0]  cls_o,
  output logic        illegal_o
);
  logic [3:0] op;
  logic bad_x, bad_yz;
  class_e c;
  assign op = ir_i[15:12];
  assign bad_x = int'(ir_i[11:8]) >= NREG;
  assign bad_yz = int'(ir_i[7:4]) >= NREG || int'(ir_i[3:0]) >= NREG;
  always_comb begin
    c = CL_ILL;
    case (op)
      OP_HALT:   c = (ir_i[11:0] == '0) ? CL_HALT : CL_ILL;
      OP_IO:     c = (ir_i[7:0] == IO_READ) ? CL_READ : (ir_i[7:0] == IO_WRITE) ? CL_WRITE : CL_ILL;
      OP_SETN:   c = CL_SETN;
      OP_LOADN:  c = CL_LOADN;
      OP_STOREN: c = CL_STOREN;
      OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_MOD: c = CL_ALU;
      OP_JUMPN:  c = CL_JUMPN;
      default:   c = CL_ILL;
    endcase
    // only register fields the instruction actually uses are range-checked
    if ((c inside {CL_READ, CL_WRITE, CL_SETN, CL_LOADN, CL_STOREN, CL_ALU} && bad_x) || (c == CL_ALU && bad_yz))
      c = CL_ILL;
  end
  assign cls_o = c;
  assign illegal_o = c == CL_ILL;
endmodule

// File: rtl/hmmm_control_seq.sv
// hmmm_control_seq: fetch/decode/execute strobe sequencer for an HMMM datapath
// Strobes come from the registered state and IR fields; only handshake inputs gate them within a state.
module hmmm_control_seq import hmmm_pkg::*; #(
  parameter int DATA_W   = 16,
  parameter int NREG     = 16,
  parameter int MEM_WAIT = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_W-1:0]       ir_data,
  input  logic                    mem_ready,
  input  logic                    in_valid,
  input  logic                    step_en,
  input  logic                    step,
  input  logic                    resume,
  output logic                    mar_in,
  output logic                    mdr_in,
  output logic                    mdr_out,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic                    pc_out,
  output logic                    pc_jump,
  output logic                    pc_increment,
  output logic                    tmp0_in,
  output logic                    tmp1_in,
  output logic                    alu_out,
  output logic                    reg_in,
  output logic                    reg_out,
  output logic                    ir_in,
  output logic                    ir_out,
  output logic                    in_out,
  output logic                    out_in,
  output logic                    halt,
  output logic                    illegal,
  output logic [2:0]              alu_op,
  output logic [$clog2(NREG)-1:0] reg_sel
);
  localparam int REGW = $clog2(NREG);
  state_e state_q, state_d;
  class_e cls_q, cls_d;
  logic [3:0] op_q, op_d, rx_q, rx_d, ry_q, ry_d, rz_q, rz_d;
  logic illegal_q, illegal_d;
  logic [3:0] dec_cls;
  logic dec_ill, rdy, go, unused_hi;
  logic [REGW-1:0] rx, ry, rz;
  assign rdy = (MEM_WAIT != 0) ? mem_ready : 1'b1;
  assign go = !(step_en && !step);
  assign rx = rx_q[REGW-1:0];
  assign ry = ry_q[REGW-1:0];
  assign rz = rz_q[REGW-1:0];
  assign unused_hi = ^ir_data;
  hmmm_decode #(.NREG(NREG)) u_decode (
    .ir_i      (ir_data[15:0]),
    .cls_o     (dec_cls),
    .illegal_o (dec_ill)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q   <= FETCH_A;
      cls_q     <= CL_HALT;
      {op_q, rx_q, ry_q, rz_q} <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      {op_q, rx_q, ry_q, rz_q} <= {op_d, rx_d, ry_d, rz_d};
      illegal_q <= illegal_d;
    end
  always_comb begin
    state_d = state_q;
    cls_d = cls_q;
    {op_d, rx_d, ry_d, rz_d} = {op_q, rx_q, ry_q, rz_q};
    illegal_d = illegal_q;
    case (state_q)
      FETCH_A: state_d = go ? FETCH_B : FETCH_A;
      FETCH_B: state_d = rdy ? DECODE : FETCH_B;
      DECODE: begin
        {op_d, rx_d, ry_d, rz_d} = ir_data[15:0];
        cls_d = class_e'(dec_cls);
        illegal_d = dec_ill;
        state_d = (class_e'(dec_cls) == CL_HALT || dec_ill) ? HALTED : EX1;
      end
      EX1: state_d = (cls_q == CL_READ && !in_valid) ? EX1 :
                     (cls_q inside {CL_LOADN, CL_STOREN, CL_ALU}) ? EX2 : FETCH_A;
      EX2: state_d = (cls_q != CL_LOADN) ? EX3 : rdy ? FETCH_A : EX2;
      EX3: state_d = (cls_q == CL_STOREN && !rdy) ? EX3 : FETCH_A;
      HALTED: begin
        state_d = resume ? FETCH_A : HALTED;
        illegal_d = illegal_q && !resume;
      end
      default: state_d = FETCH_A;
    endcase
  end
  // reset gates every output combinationally so it takes effect before the next edge
  always_comb begin
    {mar_in, mdr_in, mdr_out, mem_req, mem_we, pc_out, pc_jump, pc_increment, tmp0_in, tmp1_in,
     alu_out, reg_in, reg_out, ir_in, ir_out, in_out, out_in, halt, illegal} = '0;
    alu_op = '0;
    reg_sel = '0;
    if (rst)
      case (state_q)
        FETCH_A: {pc_out, mar_in, mem_req} = {3{go}};
        FETCH_B: begin
          mem_req = 1'b1;
          {mdr_out, ir_in, pc_increment} = {3{rdy}};
        end
        EX1:
          case (cls_q)
            CL_READ: begin
              {in_out, reg_in} = {2{in_valid}};
              reg_sel = in_valid ? rx : '0;
            end
            CL_WRITE: begin
              {reg_out, out_in} = 2'b11;
              reg_sel = rx;
            end
            CL_SETN: begin
              {ir_out, reg_in} = 2'b11;
              reg_sel = rx;
            end
            CL_LOADN, CL_STOREN: {ir_out, mar_in} = 2'b11;
            CL_ALU: begin
              {reg_out, tmp0_in} = 2'b11;
              reg_sel = ry;
            end
            CL_JUMPN: {ir_out, pc_jump} = 2'b11;
            default: ;
          endcase
        EX2:
          case (cls_q)
            CL_LOADN: begin
              mem_req = 1'b1;
              {mdr_out, reg_in} = {2{rdy}};
              reg_sel = rdy ? rx : '0;
            end
            CL_STOREN: begin
              {reg_out, mdr_in} = 2'b11;
              reg_sel = rx;
            end
            CL_ALU: begin
              {reg_out, tmp1_in} = 2'b11;
              reg_sel = rz;
            end
            default: ;
          endcase
        EX3:
          case (cls_q)
            CL_STOREN: {mem_req, mem_we} = 2'b11;
            CL_ALU: begin
              {alu_out, reg_in} = 2'b11;
              alu_op = alu_enc(op_q);
              reg_sel = rx;
            end
            default: ;
          endcase
        HALTED: begin
          halt = 1'b1;
          illegal = illegal_q;
        end
        default: ;
      endcase
  end
endmodule

// File: tb/tb_hmmm_control_seq.sv
// tb_hmmm_control_seq: random instruction streams checked against a per-instruction strobe-trace model
module tb_hmmm_control_seq;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, mem_ready, in_valid, step_en, step, resume;
  logic [15:0] ir_data;
  logic [25:0] o, o8;
  localparam logic [25:0] M_MAR  = 26'd1 << 25, M_MDRI = 26'd1 << 24, M_MDRO = 26'd1 << 23;
  localparam logic [25:0] M_REQ  = 26'd1 << 22, M_WE   = 26'd1 << 21, M_PC   = 26'd1 << 20;
  localparam logic [25:0] M_PCJ  = 26'd1 << 19, M_PCI  = 26'd1 << 18, M_T0   = 26'd1 << 17;
  localparam logic [25:0] M_T1   = 26'd1 << 16, M_ALUO = 26'd1 << 15, M_RIN  = 26'd1 << 14;
  localparam logic [25:0] M_REGO = 26'd1 << 13, M_IRIN = 26'd1 << 12, M_IRO  = 26'd1 << 11;
  localparam logic [25:0] M_INO  = 26'd1 << 10, M_OUTI = 26'd1 << 9,  M_HALT = 26'd1 << 8;
  localparam logic [25:0] M_ILL  = 26'd1 << 7;
  localparam logic [25:0] M_DRV  = M_PC | M_MDRO | M_REGO | M_IRO | M_INO | M_ALUO;
  localparam int C_HALT = 0, C_READ = 1, C_WRITE = 2, C_SETN = 3, C_LOADN = 4, C_STOREN = 5;
  localparam int C_ALU = 6, C_JUMP = 7, C_ILL = 8;
  int n_chk = 0, n_fail = 0;

  hmmm_control_seq u_dut (
    .clk(clk), .rst(rst), .ir_data(ir_data), .mem_ready(mem_ready), .in_valid(in_valid),
    .step_en(step_en), .step(step), .resume(resume),
    .mar_in(o[25]), .mdr_in(o[24]), .mdr_out(o[23]), .mem_req(o[22]), .mem_we(o[21]),
    .pc_out(o[20]), .pc_jump(o[19]), .pc_increment(o[18]), .tmp0_in(o[17]), .tmp1_in(o[16]),
    .alu_out(o[15]), .reg_in(o[14]), .reg_out(o[13]), .ir_in(o[12]), .ir_out(o[11]),
    .in_out(o[10]), .out_in(o[9]), .halt(o[8]), .illegal(o[7]), .alu_op(o[6:4]), .reg_sel(o[3:0])
  );
  hmmm_control_seq #(.NREG(8), .MEM_WAIT(0)) u_dut8 (
    .clk(clk), .rst(rst), .ir_data(ir_data), .mem_ready(1'b0), .in_valid(in_valid),
    .step_en(step_en), .step(step), .resume(resume),
    .mar_in(o8[25]), .mdr_in(o8[24]), .mdr_out(o8[23]), .mem_req(o8[22]), .mem_we(o8[21]),
    .pc_out(o8[20]), .pc_jump(o8[19]), .pc_increment(o8[18]), .tmp0_in(o8[17]), .tmp1_in(o8[16]),
    .alu_out(o8[15]), .reg_in(o8[14]), .reg_out(o8[13]), .ir_in(o8[12]), .ir_out(o8[11]),
    .in_out(o8[10]), .out_in(o8[9]), .halt(o8[8]), .illegal(o8[7]), .alu_op(o8[6:4]), .reg_sel(o8[2:0])
  );
  assign o8[3] = 1'b0;

  typedef struct {
    logic [15:0] ir;
    logic se, mr, iv, st, rs;
    logic [25:0] e;
  } item_t;
  item_t q[$];
  logic [15:0] g_ir;
  logic g_se;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  function automatic int cls_of(input logic [15:0] ir, input int nreg);
    int op = int'(ir[15:12]);
    bit bx = int'(ir[11:8]) >= nreg;
    bit byz = int'(ir[7:4]) >= nreg || int'(ir[3:0]) >= nreg;
    if (ir == 16'h0000) return C_HALT;
    if (op == 1) return (bx || !(ir[7:0] == 8'h01 || ir[7:0] == 8'h02)) ? C_ILL : (ir[7:0] == 8'h01) ? C_READ : C_WRITE;
    if (op == 2) return bx ? C_ILL : C_SETN;
    if (op == 3) return bx ? C_ILL : C_LOADN;
    if (op == 4) return bx ? C_ILL : C_STOREN;
    if (op >= 6 && op <= 10) return (bx || byz) ? C_ILL : C_ALU;
    if (op == 11) return C_JUMP;
    return C_ILL;
  endfunction

  task automatic push(input logic mr, input logic iv, input logic st, input logic rs, input logic [25:0] e);
    item_t it;
    it.ir = g_ir; it.se = g_se; it.mr = mr; it.iv = iv; it.st = st; it.rs = rs; it.e = e;
    q.push_back(it);
  endtask

  // expected cycle-by-cycle trace of one instruction, from FETCH_A back to the next FETCH_A
  task automatic gen(input logic [15:0] ir, input int nreg, input bit mw, input bit se,
                     input int wf, input int wx, input int idle, input int hk);
    int cl = cls_of(ir, nreg);
    int op = int'(ir[15:12]);
    logic [25:0] sx = 26'(int'(ir[11:8]) & (nreg - 1));
    logic [25:0] sy = 26'(int'(ir[7:4]) & (nreg - 1));
    logic [25:0] sz = 26'(int'(ir[3:0]) & (nreg - 1));
    logic [25:0] e;
    g_ir = ir;
    g_se = se;
    if (se) repeat (idle) push(rb(), rb(), 1'b0, rb(), '0);
    push(rb(), rb(), se ? 1'b1 : rb(), rb(), M_PC | M_MAR | M_REQ);
    if (mw) repeat (wf) push(1'b0, rb(), rb(), rb(), M_REQ);
    push(mw ? 1'b1 : rb(), rb(), rb(), rb(), M_REQ | M_MDRO | M_IRIN | M_PCI);
    push(rb(), rb(), rb(), rb(), '0);
    case (cl)
      C_HALT, C_ILL: begin
        e = M_HALT | ((cl == C_ILL) ? M_ILL : 26'd0);
        repeat (hk) push(rb(), rb(), rb(), 1'b0, e);
        push(rb(), rb(), rb(), 1'b1, e);
      end
      C_READ: begin
        repeat (wx) push(rb(), 1'b0, rb(), rb(), '0);
        push(rb(), 1'b1, rb(), rb(), M_INO | M_RIN | sx);
      end
      C_WRITE: push(rb(), rb(), rb(), rb(), M_REGO | M_OUTI | sx);
      C_SETN:  push(rb(), rb(), rb(), rb(), M_IRO | M_RIN | sx);
      C_JUMP:  push(rb(), rb(), rb(), rb(), M_IRO | M_PCJ);
      C_LOADN: begin
        push(rb(), rb(), rb(), rb(), M_IRO | M_MAR);
        if (mw) repeat (wx) push(1'b0, rb(), rb(), rb(), M_REQ);
        push(mw ? 1'b1 : rb(), rb(), rb(), rb(), M_REQ | M_MDRO | M_RIN | sx);
      end
      C_STOREN: begin
        push(rb(), rb(), rb(), rb(), M_IRO | M_MAR);
        push(rb(), rb(), rb(), rb(), M_REGO | M_MDRI | sx);
        if (mw) repeat (wx) push(1'b0, rb(), rb(), rb(), M_REQ | M_WE);
        push(mw ? 1'b1 : rb(), rb(), rb(), rb(), M_REQ | M_WE);
      end
      default: begin
        push(rb(), rb(), rb(), rb(), M_REGO | M_T0 | sy);
        push(rb(), rb(), rb(), rb(), M_REGO | M_T1 | sz);
        push(rb(), rb(), rb(), rb(), M_ALUO | M_RIN | (26'(op - 6) << 4) | sx);
      end
    endcase
  endtask

  task automatic gen_rand(input int nreg, input bit mw);
    logic [15:0] w = 16'($urandom);
    if (w[15:12] == 4'h1) w[7:0] = ($urandom % 4 == 0) ? 8'($urandom) : ($urandom % 2 == 0) ? 8'h01 : 8'h02;
    if (w[15:12] == 4'h0 && $urandom % 2 == 0) w = 16'h0000;
    if (nreg < 16 && $urandom % 2 == 0) w[11:0] = w[11:0] & 12'h777;
    gen(w, nreg, mw, $urandom % 4 == 0, int'($urandom % 3), int'($urandom % 3), int'($urandom % 3), int'($urandom % 3));
  endtask

  task automatic run(input bit sel8);
    int k = 0;
    while (q.size() > 0) begin
      item_t it = q.pop_front();
      ir_data = it.ir; step_en = it.se; mem_ready = it.mr; in_valid = it.iv; step = it.st; resume = it.rs;
      #3;
      chk($sformatf("%s ir=%h cyc%0d", sel8 ? "dut8" : "dut", it.ir, k), 32'(sel8 ? o8 : o), 32'(it.e));
      chk("one_driver", 32'($countones((sel8 ? o8 : o) & M_DRV) > 1), 32'd0);
      k++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    @(posedge clk);
    #4;
    chk("reset_outputs", 32'(o), 32'd0);
    chk("reset_outputs8", 32'(o8), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b1; mem_ready = 1'b0; in_valid = 1'b0; step_en = 1'b0; step = 1'b0; resume = 1'b0; ir_data = '0;
    #2;
    do_reset();
    gen(16'h6912, 8, 1'b0, 1'b0, 0, 0, 0, 1);
    gen(16'h2305, 8, 1'b0, 1'b0, 0, 0, 0, 0);
    gen(16'h3705, 8, 1'b0, 1'b0, 0, 0, 0, 0);
    run(1'b1);
    repeat (60) begin
      gen_rand(8, 1'b0);
      run(1'b1);
    end
    do_reset();
    gen(16'h612A, 16, 1'b1, 1'b0, 0, 0, 0, 0);
    gen(16'h3305, 16, 1'b1, 1'b0, 0, 3, 0, 0);
    gen(16'hF000, 16, 1'b1, 1'b0, 0, 0, 0, 2);
    gen(16'h1101, 16, 1'b1, 1'b0, 1, 2, 0, 0);
    gen(16'h2305, 16, 1'b1, 1'b1, 0, 0, 3, 0);
    gen(16'h4207, 16, 1'b1, 1'b1, 1, 2, 2, 0);
    gen(16'hA9C3, 16, 1'b1, 1'b0, 0, 0, 0, 0);
    gen(16'hB0FF, 16, 1'b1, 1'b0, 0, 0, 0, 0);
    run(1'b0);
    repeat (400) begin
      gen_rand(16, 1'b1);
      run(1'b0);
    end
    step_en = 1'b0; step = 1'b0; resume = 1'b0; mem_ready = 1'b0;
    #3;
    chk("fetch_a", 32'(o), 32'(M_PC | M_MAR | M_REQ));
    @(posedge clk);
    #3;
    chk("fetch_b_wait", 32'(o), 32'(M_REQ));
    rst = 1'b0;
    #1;
    chk("async_reset", 32'(o), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #3;
    chk("first_after_reset", 32'(o), 32'(M_PC | M_MAR | M_REQ));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
